// File: rtl/mem_recorder_pkg.sv
// mem_recorder_pkg: shared FSM state type and default recorder constants
package mem_recorder_pkg;
  typedef enum logic [1:0] {IDLE, REC, DONE} state_e;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_AW = 5;
  localparam logic [7:0] DEF_TERM = 8'h2B;
endpackage

// File: rtl/mem_recorder_rec_ram.sv
// rec_ram: DEPTH x 8 record RAM, one write port, registered read port
module rec_ram #(
  parameter int DEPTH = 32,
  parameter int AW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);
  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;
  always_ff @(posedge i_clk)
    if (i_we) mem_q[i_wr_addr] <= i_wr_data;
  // only the output register is reset; the array itself stays reset-free
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) rd_data_q <= '0;
    else rd_data_q <= mem_q[i_rd_addr];
  assign o_rd_data = rd_data_q;
endmodule

// File: rtl/mem_recorder.sv
// mem_recorder: records a non-zero byte stream into RAM until TERM arrives or RAM fills
module mem_recorder
  import mem_recorder_pkg::*;
#(
  parameter int         DEPTH = DEF_DEPTH,
  parameter int         AW    = DEF_AW,
  parameter logic [7:0] TERM  = DEF_TERM
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [7:0]    i_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic [AW:0]   o_count,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_full
);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH-1);
  state_e state_q, state_d;
  logic [AW:0] count_q, count_d;
  logic full_q, full_d;
  logic we, term, last;
  assign we = |i_data && state_q != DONE;
  assign term = i_data == TERM;
  assign last = count_q == LAST;
  // count is 0 in IDLE, so it doubles as the write pointer in every writing state
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    full_d  = full_q;
    if (we) begin
      count_d = count_q + 1'b1;
      state_d = term || last ? DONE : REC;
      full_d  = !term && last;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  rec_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_we      (we),
    .i_wr_addr (count_q[AW-1:0]),
    .i_wr_data (i_data),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data)
  );
  assign o_count = count_q;
  assign o_busy  = state_q == REC;
  assign o_done  = state_q == DONE;
  assign o_full  = full_q;
endmodule

// File: tb/tb_mem_recorder.sv
// tb_mem_recorder: directed tests of mem_recorder with hand-computed expectations
module tb_mem_recorder;
  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic [4:0] i_rd_addr = '0;
  logic [7:0] o_rd_data;
  logic [5:0] o_count;
  logic       o_busy, o_done, o_full;
  int n_chk = 0;
  int n_fail = 0;
  string msg = "HERASHCHENKO_ARTEM_DK91+";

  mem_recorder dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_data    (i_data),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data),
    .o_count   (o_count),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_full    (o_full)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    i_data = b;
    @(negedge i_clk);
    i_data = 8'h00;
  endtask

  task automatic rd(input string tag, input int a, input logic [7:0] exp);
    i_rd_addr = 5'(a);
    @(negedge i_clk);
    chk(tag, {24'h0, o_rd_data}, {24'h0, exp});
  endtask

  task automatic flags(input string tag, input int cnt, input logic busy, input logic done, input logic full);
    chk({tag, ".count"}, 32'(o_count), 32'(cnt));
    chk({tag, ".busy"}, 32'(o_busy), 32'(busy));
    chk({tag, ".done"}, 32'(o_done), 32'(done));
    chk({tag, ".full"}, 32'(o_full), 32'(full));
  endtask

  task automatic do_reset();
    #2 i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    #1 i_rst_n = 1'b0;
    #1 flags("reset", 0, 0, 0, 0);
    chk("reset.rd_data", {24'h0, o_rd_data}, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    send(8'h00);
    flags("idle_zero", 0, 0, 0, 0);

    // contiguous stream
    send(msg[0]);
    flags("first_byte", 1, 1, 0, 0);
    for (int i = 1; i < 24; i++) send(msg[i]);
    flags("stream", 24, 0, 1, 0);
    send("X"); send("Y"); send(8'h2B);
    flags("after_term", 24, 0, 1, 0);
    rd("stream.mem0", 0, 8'h48);
    rd("stream.mem12", 12, 8'h5F);
    rd("stream.mem23", 23, 8'h2B);
    rd("stream.mem24", 24, 8'hxx);
    for (int i = 0; i < 24; i++) rd($sformatf("sweep1[%0d]", i), i, msg[i]);

    // stream with zero gaps
    do_reset();
    for (int i = 0; i < 24; i++) begin
      send(msg[i]);
      send(8'h00);
      if (i < 23) chk($sformatf("gap_busy[%0d]", i), 32'(o_busy), 32'd1);
    end
    flags("gaps", 24, 0, 1, 0);
    for (int i = 0; i < 24; i++) rd($sformatf("sweep2[%0d]", i), i, msg[i]);

    // fill without terminator
    do_reset();
    for (int i = 0; i < 31; i++) send(8'h41);
    flags("fill31", 31, 1, 0, 0);
    send(8'h41);
    flags("fill32", 32, 0, 1, 1);
    send(8'h2B);
    flags("fill_term", 32, 0, 1, 1);
    rd("fill.mem0", 0, 8'h41);
    rd("fill.mem31", 31, 8'h41);

    // terminator as first byte
    do_reset();
    send(8'h2B);
    flags("term_first", 1, 0, 1, 0);
    rd("term_first.mem0", 0, 8'h2B);

    // asynchronous reset mid-recording, then read-before-write on address 0
    do_reset();
    for (int i = 0; i < 5; i++) send(msg[i]);
    flags("heras", 5, 1, 0, 0);
    #2 i_rst_n = 1'b0;
    #1 flags("async_rst", 0, 0, 0, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_rd_addr = 5'd0;
    @(negedge i_clk);
    send(8'h41);
    chk("rbw.mem0_old", {24'h0, o_rd_data}, 32'h48);
    send(8'h42);
    send(8'h2B);
    flags("ab_term", 3, 0, 1, 0);
    rd("ab.mem0", 0, 8'h41);
    rd("ab.mem1", 1, 8'h42);
    rd("ab.mem2", 2, 8'h2B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
